// File: rtl/main_decoder_if.sv
// ============================================================================
// Module      : main_decoder_if
// Description : Opcode/funct3 input bundle and decoded control outputs for the
//               RV32I main decoder. The illegal flag exists only when
//               MAIN_DECODER_ILLEGAL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface main_decoder_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       reg_write;
    logic       ALU_select;
    logic [3:0] memory_control;
    logic [2:0] result_select;
    logic       branch;
    logic [1:0] ALU_op;
    logic       jump;
`ifdef MAIN_DECODER_ILLEGAL_EN
    logic       illegal;
`endif

    // Instruction source side
    modport master (
        output opcode,
        output funct3,
        input  reg_write,
        input  ALU_select,
        input  memory_control,
        input  result_select,
        input  branch,
        input  ALU_op,
        input  jump
`ifdef MAIN_DECODER_ILLEGAL_EN
        ,
        input  illegal
`endif
    );

    // Decoder side
    modport slave (
        input  opcode,
        input  funct3,
        output reg_write,
        output ALU_select,
        output memory_control,
        output result_select,
        output branch,
        output ALU_op,
        output jump
`ifdef MAIN_DECODER_ILLEGAL_EN
        ,
        output illegal
`endif
    );
endinterface

`default_nettype wire

// File: rtl/main_decoder.sv
// ============================================================================
// Module      : main_decoder
// Description : RV32I main control decoder; opcode (+funct3 for load/store)
//               to registered datapath controls, one-cycle latency.
//               Optional illegal-instruction flag: MAIN_DECODER_ILLEGAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_decoder (
    input  wire          clock,
    input  wire          reset,
    main_decoder_if.slave bus
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [2:0] c_RES_ALU   = 3'b000;
    localparam logic [2:0] c_RES_MEM   = 3'b001;
    localparam logic [2:0] c_RES_PC4   = 3'b010;
    localparam logic [2:0] c_RES_IMM   = 3'b011;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    logic       w_reg_write;
    logic       w_alu_select;
    logic [3:0] w_memory_control;
    logic [2:0] w_result_select;
    logic       w_branch;
    logic [1:0] w_alu_op;
    logic       w_jump;

    logic       r_reg_write;
    logic       r_alu_select;
    logic [3:0] r_memory_control;
    logic [2:0] r_result_select;
    logic       r_branch;
    logic [1:0] r_alu_op;
    logic       r_jump;

`ifdef MAIN_DECODER_ILLEGAL_EN
    logic       w_known;
    logic       w_illegal;
    logic       r_illegal;
`endif

    always_comb begin
        w_reg_write      = 1'b0;
        w_alu_select     = 1'b0;
        w_memory_control = 4'b0000;
        w_result_select  = c_RES_ALU;
        w_branch         = 1'b0;
        w_alu_op         = c_ALU_ADD;
        w_jump           = 1'b0;
`ifdef MAIN_DECODER_ILLEGAL_EN
        w_known          = 1'b1;
`endif
        case (bus.opcode)
            c_OP_LOAD: begin
                w_reg_write      = 1'b1;
                w_alu_select     = 1'b1;
                w_memory_control = {1'b0, bus.funct3};
                w_result_select  = c_RES_MEM;
            end
            c_OP_STORE: begin
                w_alu_select     = 1'b1;
                w_memory_control = {1'b1, bus.funct3};
            end
            c_OP_RTYPE: begin
                w_reg_write      = 1'b1;
                w_alu_op         = c_ALU_FUNCT;
            end
            c_OP_BRANCH: begin
                w_branch         = 1'b1;
                w_alu_op         = c_ALU_SUB;
            end
            c_OP_ITYPE: begin
                w_reg_write      = 1'b1;
                w_alu_select     = 1'b1;
                w_alu_op         = c_ALU_FUNCT;
            end
            c_OP_JAL: begin
                w_reg_write      = 1'b1;
                w_result_select  = c_RES_PC4;
                w_jump           = 1'b1;
            end
            c_OP_LUI: begin
                w_reg_write      = 1'b1;
                w_result_select  = c_RES_IMM;
            end
            default: begin
`ifdef MAIN_DECODER_ILLEGAL_EN
                w_known          = 1'b0;
`endif
            end
        endcase

`ifdef MAIN_DECODER_ILLEGAL_EN
        // Reserved load sizes are 011/110/111; stores only define sb/sh/sw.
        w_illegal = !w_known
                 || ((bus.opcode == c_OP_LOAD) &&
                     ((bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                      (bus.funct3 == 3'b111)))
                 || ((bus.opcode == c_OP_STORE) && (bus.funct3 > 3'b010));
        if (w_illegal) begin
            w_reg_write      = 1'b0;
            w_alu_select     = 1'b0;
            w_memory_control = 4'b0000;
            w_result_select  = c_RES_ALU;
            w_branch         = 1'b0;
            w_alu_op         = c_ALU_ADD;
            w_jump           = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_reg_write      <= 1'b0;
            r_alu_select     <= 1'b0;
            r_memory_control <= 4'b0000;
            r_result_select  <= 3'b000;
            r_branch         <= 1'b0;
            r_alu_op         <= 2'b00;
            r_jump           <= 1'b0;
`ifdef MAIN_DECODER_ILLEGAL_EN
            r_illegal        <= 1'b0;
`endif
        end else begin
            r_reg_write      <= w_reg_write;
            r_alu_select     <= w_alu_select;
            r_memory_control <= w_memory_control;
            r_result_select  <= w_result_select;
            r_branch         <= w_branch;
            r_alu_op         <= w_alu_op;
            r_jump           <= w_jump;
`ifdef MAIN_DECODER_ILLEGAL_EN
            r_illegal        <= w_illegal;
`endif
        end
    end

    assign bus.reg_write      = r_reg_write;
    assign bus.ALU_select     = r_alu_select;
    assign bus.memory_control = r_memory_control;
    assign bus.result_select  = r_result_select;
    assign bus.branch         = r_branch;
    assign bus.ALU_op         = r_alu_op;
    assign bus.jump           = r_jump;
`ifdef MAIN_DECODER_ILLEGAL_EN
    assign bus.illegal        = r_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_main_decoder.sv
// ============================================================================
// Module      : tb_main_decoder
// Description : Scoreboard bench for main_decoder with a table-driven model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_decoder;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    main_decoder_if bus ();

    main_decoder u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int passes = 0;

    // Packed as {illegal, reg_write, ALU_select, memory_control[3:0],
    //            result_select[2:0], branch, ALU_op[1:0], jump}
    bit [12:0]  dec_table [bit [6:0]];
    logic [13:0] exp_q [$];
    logic [13:0] last_exp;
    bit          have_last = 0;
    bit          sb_on     = 0;

    function automatic logic [13:0] model(input bit [6:0] op, input bit [2:0] f3);
        bit [12:0] v;
        bit        ill;
        v   = dec_table.exists(op) ? dec_table[op] : 13'd0;
        if (op == 7'b0000011 || op == 7'b0100011) v[9:7] = f3;
        ill = 1'b0;
`ifdef MAIN_DECODER_ILLEGAL_EN
        ill = !dec_table.exists(op)
           || (op == 7'b0000011 && (f3 == 3 || f3 == 6 || f3 == 7))
           || (op == 7'b0100011 && f3 > 2);
        if (ill) v = 13'd0;
`endif
        return {ill, v};
    endfunction

    function automatic logic [13:0] actual();
        logic ill;
        ill = 1'b0;
`ifdef MAIN_DECODER_ILLEGAL_EN
        ill = bus.illegal;
`endif
        return {ill, bus.reg_write, bus.ALU_select, bus.memory_control,
                bus.result_select, bus.branch, bus.ALU_op, bus.jump};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input bit [6:0] op, input bit [2:0] f3);
        @(negedge clock);
        bus.opcode = op;
        bus.funct3 = f3;
        exp_q.push_back(model(op, f3));
    endtask

    // Monitor: outputs sampled after each rising edge against the oldest expectation.
    always begin
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            have_last = 1;
            check("decode", actual(), last_exp);
        end
    end

    // Mid-cycle: fresh inputs must not reach the outputs before the next edge.
    always begin
        @(negedge clock);
        #2;
        if (sb_on && have_last) check("latency_hold", actual(), last_exp);
    end

    bit [6:0] ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                          7'b0010011, 7'b1101111, 7'b0110111};

    initial begin
        bit [6:0] op;
        dec_table[7'b0000011] = 13'b1_1_0000_001_0_00_0;
        dec_table[7'b0100011] = 13'b0_1_1000_000_0_00_0;
        dec_table[7'b0110011] = 13'b1_0_0000_000_0_10_0;
        dec_table[7'b1100011] = 13'b0_0_0000_000_1_01_0;
        dec_table[7'b0010011] = 13'b1_1_0000_000_0_10_0;
        dec_table[7'b1101111] = 13'b1_0_0000_010_0_00_1;
        dec_table[7'b0110111] = 13'b1_0_0000_011_0_00_0;

        // Reset behaviour
        bus.opcode = 7'b0110011;
        bus.funct3 = 3'b000;
        @(negedge clock);
        check("pre_reset_rtype", actual(), model(7'b0110011, 3'b000));
        #2 reset = 1'b1;
        #1 check("async_reset", actual(), 14'd0);
        @(posedge clock);
        @(posedge clock);
        #1 check("reset_hold", actual(), 14'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("post_deassert_no_edge", actual(), 14'd0);
        @(posedge clock);
        #1 check("first_decode", actual(), model(7'b0110011, 3'b000));

        // Directed sequence, then randomized traffic
        sb_on = 1;
        drive(7'b0000011, 3'b010);
        drive(7'b0100011, 3'b010);
        drive(7'b0110011, 3'b101);
        drive(7'b1100011, 3'b001);
        drive(7'b0010011, 3'b000);
        drive(7'b1101111, 3'b111);
        drive(7'b0110111, 3'b011);
        drive(7'b1111111, 3'b000);
        drive(7'b0000000, 3'b000);
        drive(7'b0000011, 3'b011);
        drive(7'b0100011, 3'b011);
        drive(7'b0000011, 3'b110);
        drive(7'b0100011, 3'b001);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) op = ops[$urandom_range(0, 6)];
            else                           op = 7'($urandom);
            drive(op, 3'($urandom));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        sb_on = 0;

        // Reset asserted mid-operation with a live opcode
        @(negedge clock);
        bus.opcode = 7'b1101111;
        @(posedge clock);
        #1 check("pre_midop_jal", actual(), model(7'b1101111, 3'b000));
        #2 reset = 1'b1;
        #1 check("reset_midop", actual(), 14'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Main control decoder for the team's RV32I CPU core.
- Maps the 7-bit instruction opcode, plus funct3 for memory ops, to datapath control signals: register write, ALU operand select, memory control, result mux select, branch, ALU op class, jump.
- Outputs are registered: one-cycle latency, feeding the execute-stage control pipeline.
- Sits between instruction fetch/decode and the ALU decoder and datapath muxes.

Parameters:
- none (all widths fixed by the RV32I encoding)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all outputs
- opcode  input  7  instruction bits [6:0]
- funct3  input  3  instruction bits [14:12]
- reg_write  output  1  1 = write result to rd
- ALU_select  output  1  ALU operand B: 0 = rs2, 1 = immediate
- memory_control  output  4  [3] = store enable; [2:0] = access size/sign (funct3 copy); 0000 = no access
- result_select  output  3  000 ALU, 001 memory read data, 010 PC+4, 011 immediate (lui); others reserved
- branch  output  1  1 = conditional branch instruction
- ALU_op  output  2  00 add, 01 subtract/compare, 10 decode via funct3/funct7, 11 unused
- jump  output  1  1 = unconditional jump

Behaviour:
- Reset: on async assertion of reset, all outputs go to 0 immediately, with no clock edge needed. They are held at 0 while reset is high. The first decode after deassertion appears on the next rising edge.
- Latency: decode is combinational from opcode/funct3 and captured into output registers on each rising clock edge. Outputs reflect the inputs sampled at the previous edge (1-cycle latency). There is no enable and no handshake; the block decodes every cycle.
- Decode table, listed as reg_write, ALU_select, memory_control, result_select, branch, ALU_op, jump:
  - 0000011 load: 1, 1, {0,funct3}, 001, 0, 00, 0
  - 0100011 store: 0, 1, {1,funct3}, 000, 0, 00, 0
  - 0110011 R-type: 1, 0, 0000, 000, 0, 10, 0
  - 1100011 branch: 0, 0, 0000, 000, 1, 01, 0
  - 0010011 I-type ALU: 1, 1, 0000, 000, 0, 10, 0
  - 1101111 jal: 1, 0, 0000, 010, 0, 00, 1
  - 0110111 lui: 1, 0, 0000, 011, 0, 00, 0
- Any other opcode, including 0000000 and 1111111: all outputs 0. This is a safe NOP: no register write, no store, no jump or branch.
- funct3 affects only memory_control, and only for load/store opcodes. For all other opcodes funct3 is ignored.
- funct3 is passed through unchecked: illegal size codes still produce {x,funct3}.
- Reset asserted mid-operation forces outputs to 0 regardless of the inputs. Reset has priority over the clock.

Optional Feature:
- Macro: MAIN_DECODER_ILLEGAL_EN.
- Defined: adds output port illegal (1 bit), registered with the same latency and reset value 0. It is 1 when:
  - the opcode is not in the decode table, or
  - load funct3 is one of 011, 110, 111, or
  - store funct3 is above 010.
- When illegal is 1, all other outputs are forced to 0 for that cycle. This includes illegal load/store funct3.
- Undefined: no illegal port. Unknown opcodes decode to all zeros, and load/store funct3 passes through unchecked.

Test Plan:
- Reset: assert reset with opcode=0110011 and no clock edge -> all outputs 0 immediately. Deassert, then one edge -> reg_write=1, ALU_op=10.
- Load: opcode=0000011, funct3=010, one edge -> reg_write=1, ALU_select=1, memory_control=0010, result_select=001, branch=0, ALU_op=00, jump=0.
- Store: opcode=0100011, funct3=010 -> reg_write=0, ALU_select=1, memory_control=1010, result_select=000. Then branch opcode=1100011 -> branch=1, ALU_op=01, memory_control=0000.
- I-type/jal/lui: opcode=0010011 -> reg_write=1, ALU_select=1, ALU_op=10. Then 1101111 -> jump=1, result_select=010, reg_write=1. Then 0110111 -> result_select=011, reg_write=1.
- Unknown: opcode=1111111 and opcode=0000000 -> all outputs 0. With MAIN_DECODER_ILLEGAL_EN: illegal=1 for both, and illegal=1 for a load with funct3=011.
- Latency: change opcode each cycle in the sequence load, store, R, branch -> each output set appears exactly one edge after its opcode and never on the same edge.
